// File: rtl/stdout_uart_tx.sv
// stdout_uart_tx: buffers processor stdout bytes in a FIFO and sends them as 8N1 UART frames
module stdout_uart_tx #(
  parameter int CLK_DIV    = 104,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    stdout,
  input  logic                          stdout_en,
  output logic                          tx,
  output logic                          busy,
  output logic                          stall,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [AW:0]   L_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   L_HIGH = (AW+1)'(FIFO_DEPTH-1);
  localparam logic [BW-1:0] L_BMAX = BW'(CLK_DIV-1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        r_state, w_state;
  logic [BW-1:0] r_baud, w_baud;
  logic [2:0]    r_idx, w_idx;
  logic [7:0]    r_sh, w_sh;
  logic          r_tx, w_tx;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic [7:0]    w_head;
  logic          w_avail, w_tc, w_pop, w_wr;
  assign w_head   = r_mem[r_rp];
  assign w_avail  = r_count != '0;
  assign w_tc     = r_baud == '0;
  assign w_pop    = w_avail && (r_state == IDLE || (r_state == STOP && w_tc));
  assign w_wr     = stdout_en && (r_count != L_FULL || w_pop);
  assign tx       = r_tx;
  assign overflow = r_ovf;
  assign count    = r_count;
  assign stall    = r_count >= L_HIGH;
  assign busy     = r_state != IDLE || w_avail;
  // FIFO storage; contents need no reset since pointers and count qualify them
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= stdout;
  // FIFO pointers, occupancy and sticky drop flag
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_wp    <= w_wr ? r_wp + 1'b1 : r_wp;
      r_rp    <= w_pop ? r_rp + 1'b1 : r_rp;
      r_count <= r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};
      r_ovf   <= r_ovf || (stdout_en && !w_wr);
    end
  // Transmitter state register; reset abandons any frame and drives the line idle
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_idx   <= '0;
      r_sh    <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state;
      r_baud  <= w_baud;
      r_idx   <= w_idx;
      r_sh    <= w_sh;
      r_tx    <= w_tx;
    end
  // Next-state and registered line value; STOP chains straight into START when data waits
  always_comb begin
    w_state = r_state;
    w_baud  = w_tc ? L_BMAX : r_baud - 1'b1;
    w_idx   = r_idx;
    w_sh    = r_sh;
    w_tx    = r_tx;
    case (r_state)
      IDLE: begin
        w_baud = L_BMAX;
        w_tx   = !w_avail;
        w_state = w_avail ? START : IDLE;
        w_sh   = w_avail ? w_head : r_sh;
      end
      START: if (w_tc) begin
        w_state = DATA;
        w_idx   = '0;
        w_tx    = r_sh[0];
      end
      DATA: if (w_tc) begin
        if (r_idx == 3'd7) begin
          w_state = STOP;
          w_tx    = 1'b1;
        end else begin
          w_sh  = r_sh >> 1;
          w_idx = r_idx + 1'b1;
          w_tx  = r_sh[1];
        end
      end
      STOP: if (w_tc) begin
        w_state = w_avail ? START : IDLE;
        w_sh    = w_avail ? w_head : r_sh;
        w_tx    = !w_avail;
      end
      default: w_state = IDLE;
    endcase
  end
endmodule
